// File: rtl/quadra_pkg.sv
// Shared constants and types for the quadra evaluation pipeline and its
// front ends.
//   N_REQ_DEF : default number of requester channels on the arbiter
//   LAT_DEF   : quadra_top latency from x_dv to y_dv, in cycles
//   X_W / Y_W : operand / result widths (fixed for every instance)
//   req_id_t  : encoded requester id for the default channel count
package quadra_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned LAT_DEF   = 3;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 16;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/quadra_rr_pick.sv
// Purely combinational round-robin picker.
//   elig   : eligible channel vector
//   rr_ptr : last granted channel; search begins at rr_ptr+1 (mod N_REQ)
//   grant  : one-hot grant (zero when nothing is eligible)
//   gid    : encoded id of the granted channel
//   gvalid : a grant was made
module quadra_rr_pick
  import quadra_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = $clog2(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gid,
  output logic             gvalid
);

  always_comb begin
    grant  = '0;
    gid    = '0;
    gvalid = 1'b0;
    // k runs 1..N_REQ so the last-granted channel is examined last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      automatic logic [ID_W-1:0] sel = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!gvalid && elig[sel]) begin
        grant[sel] = 1'b1;
        gid        = sel;
        gvalid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadra_arbiter.sv
// Round-robin front end sharing one quadra_top pipeline between N_REQ
// requesters. Issues at most one operand per cycle; a tag pipe matched to the
// pipeline latency steers each result into a per-channel response register.
//   clk, rst_b          : clock (rising edge), asynchronous active-low reset
//   en                  : grant enable; in-flight work completes when low
//   req_valid/req_x     : per-channel operand offer (req_x packed N_REQ x X_W)
//   req_ready           : one-hot or zero accept strobe (combinational)
//   rsp_valid/rsp_y     : per-channel held result (rsp_y packed N_REQ x Y_W)
//   rsp_ready           : consumer takes result
//   q_x/q_x_dv          : operand into quadra_top
//   q_y/q_y_dv          : result from quadra_top
//   idle                : no channel busy and tag pipe empty
//   err                 : sticky; result/tag misalignment seen
module quadra_arbiter
  import quadra_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 en,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*X_W-1:0] req_x,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [N_REQ*Y_W-1:0] rsp_y,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [X_W-1:0]       q_x,
  output logic                 q_x_dv,
  input  logic [Y_W-1:0]       q_y,
  input  logic                 q_y_dv,
  output logic                 idle,
  output logic                 err
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         busy;
  logic [N_REQ-1:0]         elig;
  logic [N_REQ-1:0]         grant;
  logic [ID_W-1:0]          gid;
  logic                     gvalid;
  logic [ID_W-1:0]          rr_ptr;
  // Tag pipe: index 0 loaded at accept, index LAT lines up with q_y_dv.
  logic [LAT:0]             tag_v;
  logic [LAT:0][ID_W-1:0]   tag_id;

  // rst_b gating keeps req_ready low while reset is held.
  assign elig      = req_valid & ~busy & {N_REQ{en & rst_b}};
  assign req_ready = grant;
  assign idle      = ~|busy && ~|tag_v;

  quadra_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .gid    (gid),
    .gvalid (gvalid)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr    <= ID_W'(N_REQ - 1);
      busy      <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      q_x       <= '0;
      q_x_dv    <= 1'b0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      err       <= 1'b0;
    end else begin
      q_x_dv <= gvalid;
      if (gvalid) begin
        q_x    <= req_x[gid*X_W +: X_W];
        rr_ptr <= gid;
      end

      tag_v  <= {tag_v[LAT-1:0], gvalid};
      tag_id <= {tag_id[LAT-1:0], gid};

      // A grant never targets a busy channel, so set and clear cannot collide.
      busy <= (busy & ~(rsp_valid & rsp_ready)) | grant;

      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (q_y_dv && tag_v[LAT] && (tag_id[LAT] == ID_W'(i))) begin
          rsp_valid[i]          <= 1'b1;
          rsp_y[i*Y_W +: Y_W]   <= q_y;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end

      // Covers both a stray result and a missing result; busy stays set.
      if (q_y_dv != tag_v[LAT]) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quadra_arbiter.sv
module tb_quadra_arbiter;
  import quadra_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned L = 3;

  logic               clk = 1'b0;
  logic               rst_b;
  logic               en;
  logic [N-1:0]       req_valid;
  logic [N*X_W-1:0]   req_x;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [N*Y_W-1:0]   rsp_y;
  logic [N-1:0]       rsp_ready;
  logic [X_W-1:0]     q_x;
  logic               q_x_dv;
  logic [Y_W-1:0]     q_y;
  logic               q_y_dv;
  logic               idle;
  logic               err;
  logic               drop;
  logic               inject;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;

  always #5 clk = ~clk;

  // quadra_top stand-in: LAT-cycle pipe computing y = 2*x + 1.
  logic [L-1:0]   sdv;
  logic [Y_W-1:0] sy [L];

  function automatic logic [Y_W-1:0] y_of(input logic [X_W-1:0] x);
    return (Y_W'(x) << 1) | Y_W'(1);
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sdv <= '0;
      for (int i = 0; i < int'(L); i++) sy[i] <= '0;
    end else begin
      sdv   <= {sdv[L-2:0], q_x_dv};
      sy[0] <= y_of(q_x);
      for (int i = 1; i < int'(L); i++) sy[i] <= sy[i-1];
    end
  end

  assign q_y    = sy[L-1];
  assign q_y_dv = (sdv[L-1] & ~drop) | inject;

  quadra_arbiter #(
    .N_REQ (N),
    .LAT   (L)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (en),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_ready (rsp_ready),
    .q_x       (q_x),
    .q_x_dv    (q_x_dv),
    .q_y       (q_y),
    .q_y_dv    (q_y_dv),
    .idle      (idle),
    .err       (err)
  );

  // Reference model: per-channel busy/response state with result due-times
  // expressed in clock-edge numbers rather than a tag pipeline.
  logic [N-1:0]   m_busy;
  logic [N-1:0]   m_rspv;
  logic [Y_W-1:0] m_rspy [N];
  logic [Y_W-1:0] m_pend [N];
  int             m_due  [N];
  int             m_rr;
  logic           m_qdv;
  logic [X_W-1:0] m_qx;
  int             m_edge;

  function automatic int model_pick();
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (m_rr + k) % int'(N);
      if (en && rst_b && req_valid[c] && !m_busy[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_init();
    m_busy = '0;
    m_rspv = '0;
    m_rr   = int'(N) - 1;
    m_qdv  = 1'b0;
    m_qx   = '0;
    m_edge = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_rspy[i] = '0;
      m_pend[i] = '0;
      m_due[i]  = -1;
    end
  endtask

  task automatic model_edge();
    int g;
    g = model_pick();
    m_edge++;
    for (int i = 0; i < int'(N); i++) begin
      if (m_rspv[i] && rsp_ready[i]) begin
        m_rspv[i] = 1'b0;
        m_busy[i] = 1'b0;
      end
    end
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_rr      = g;
      m_qdv     = 1'b1;
      m_qx      = req_x[g*X_W +: X_W];
      m_pend[g] = y_of(m_qx);
      m_due[g]  = m_edge + int'(L) + 1;
    end else begin
      m_qdv = 1'b0;
    end
    for (int i = 0; i < int'(N); i++) begin
      if (m_due[i] == m_edge) begin
        m_rspv[i] = 1'b1;
        m_rspy[i] = m_pend[i];
        m_due[i]  = -1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [N-1:0] rv);
    rst_b     = 1'b0;
    en        = 1'b1;
    req_valid = rv;
    req_x     = '0;
    rsp_ready = '1;
    drop      = 1'b0;
    inject    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    model_init();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    req_valid = '1;
    en = 1'b1;
    rsp_ready = '1;
    drop = 1'b0;
    inject = 1'b0;
    req_x = '0;
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_ready_held: got %b want 0", req_ready); else n_pass++;
    do_reset('0);
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_y !== '0) $display("FAIL reset_rsp_y: got %h want 0", rsp_y); else n_pass++;
    n_checks++; if (q_x !== '0 || q_x_dv !== 1'b0) $display("FAIL reset_q: got x=%h dv=%b want 0/0", q_x, q_x_dv); else n_pass++;
    n_checks++; if (idle !== 1'b1 || err !== 1'b0) $display("FAIL reset_idle_err: got idle=%b err=%b want 1/0", idle, err); else n_pass++;
  endtask

  task automatic test_single();
    do_reset('0);
    req_x[0 +: X_W] = 8'd5;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_checks++; if (q_x_dv !== 1'b1 || q_x !== 8'd5) $display("FAIL single_issue: got dv=%b x=%0d want 1/5", q_x_dv, q_x); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL single_busy: got idle=%b want 0", idle); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (rsp_valid !== '0) $display("FAIL single_early_rsp: cycle %0d got %b want 0", c, rsp_valid); else n_pass++;
    end
    tick();
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_y[0 +: Y_W] !== 16'd11) $display("FAIL single_rsp: got v=%b y=%0d want 0001/11", rsp_valid, rsp_y[0 +: Y_W]); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== '0 || idle !== 1'b1) $display("FAIL single_done: got v=%b idle=%b want 0/1", rsp_valid, idle); else n_pass++;
  endtask

  task automatic test_all_channels();
    logic [N-1:0] exp_r;
    logic [N-1:0] exp_v;
    do_reset('1);
    for (int i = 0; i < int'(N); i++) req_x[i*X_W +: X_W] = X_W'(i + 10);
    for (int s = 0; s <= 10; s++) begin
      #1;
      exp_r = (s < 4) ? (N'(1) << s) : '0;
      exp_v = (s >= 5 && s <= 8) ? (N'(1) << (s - 5)) : '0;
      n_checks++; if (req_ready !== exp_r) $display("FAIL all_grant s=%0d: got %b want %b", s, req_ready, exp_r); else n_pass++;
      n_checks++; if (rsp_valid !== exp_v) $display("FAIL all_rsp_valid s=%0d: got %b want %b", s, rsp_valid, exp_v); else n_pass++;
      if (s >= 5 && s <= 8) begin
        n_checks++;
        if (rsp_y[(s-5)*Y_W +: Y_W] !== Y_W'(21 + 2*(s-5)))
          $display("FAIL all_rsp_y ch%0d: got %0d want %0d", s-5, rsp_y[(s-5)*Y_W +: Y_W], 21 + 2*(s-5));
        else n_pass++;
      end
      if (s == 10) begin
        n_checks++; if (idle !== 1'b1) $display("FAIL all_idle: got %b want 1", idle); else n_pass++;
      end
      tick();
      if (s < 4) req_valid[s] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int gcnt [N];
    logic [Y_W-1:0] y1_exp;
    logic [Y_W-1:0] y1_seen;
    logic seen;
    logic unstable;
    do_reset('1);
    rsp_ready = 4'b1101;
    y1_exp = '0;
    y1_seen = '0;
    seen = 1'b0;
    unstable = 1'b0;
    for (int i = 0; i < int'(N); i++) gcnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < int'(N); i++) req_x[i*X_W +: X_W] = X_W'($urandom);
      #1;
      for (int i = 0; i < int'(N); i++) if (req_ready[i]) gcnt[i]++;
      if (req_ready[1]) y1_exp = y_of(req_x[X_W +: X_W]);
      if (rsp_valid[1]) begin
        if (!seen) begin
          seen = 1'b1;
          y1_seen = rsp_y[Y_W +: Y_W];
        end else if (rsp_y[Y_W +: Y_W] !== y1_seen) begin
          unstable = 1'b1;
        end
      end
      tick();
    end
    n_checks++; if (gcnt[1] != 1) $display("FAIL bp_ch1_grants: got %0d want 1", gcnt[1]); else n_pass++;
    n_checks++; if (seen !== 1'b1 || y1_seen !== y1_exp) $display("FAIL bp_ch1_rsp: got seen=%b y=%0d want 1/%0d", seen, y1_seen, y1_exp); else n_pass++;
    n_checks++; if (unstable !== 1'b0) $display("FAIL bp_ch1_stable: got unstable=%b want 0", unstable); else n_pass++;
    for (int i = 0; i < int'(N); i++) begin
      if (i != 1) begin
        n_checks++; if (gcnt[i] < 2) $display("FAIL bp_others ch%0d: got %0d grants want >=2", i, gcnt[i]); else n_pass++;
      end
    end
    req_valid = '0;
    rsp_ready = '1;
    #1;
    n_checks++; if (rsp_valid[1] !== 1'b1) $display("FAIL bp_hold: got %b want 1", rsp_valid[1]); else n_pass++;
    tick();
    n_checks++; if (rsp_valid[1] !== 1'b0) $display("FAIL bp_release: got %b want 0", rsp_valid[1]); else n_pass++;
  endtask

  task automatic test_en_drop();
    logic got0;
    logic got2;
    do_reset('0);
    got0 = 1'b0;
    got2 = 1'b0;
    req_x[0 +: X_W]     = 8'd3;
    req_x[2*X_W +: X_W] = 8'd9;
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL en_grant0: got %b want 0001", req_ready); else n_pass++;
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL en_grant2: got %b want 0100", req_ready); else n_pass++;
    tick();
    en = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (req_ready !== '0) $display("FAIL en_no_grant c=%0d: got %b want 0", c, req_ready); else n_pass++;
      if (rsp_valid[0] && rsp_y[0 +: Y_W] === 16'd7) got0 = 1'b1;
      if (rsp_valid[2] && rsp_y[2*Y_W +: Y_W] === 16'd19) got2 = 1'b1;
      tick();
    end
    n_checks++; if (got0 !== 1'b1 || got2 !== 1'b1) $display("FAIL en_drain: got ch0=%b ch2=%b want 1/1", got0, got2); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL en_idle: got %b want 1", idle); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset('0);
    inject = 1'b1;
    #1;
    tick();
    inject = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1) $display("FAIL err_stray: got %b want 1", err); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL err_stray_rsp: got %b want 0", rsp_valid); else n_pass++;
    for (int c = 0; c < 3; c++) tick();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;

    do_reset('0);
    #1;
    n_checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else n_pass++;
    drop = 1'b1;
    req_x[3*X_W +: X_W] = 8'd7;
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL err_grant3: got %b want 1000", req_ready); else n_pass++;
    for (int c = 0; c < 8; c++) tick();
    #1;
    n_checks++; if (err !== 1'b1) $display("FAIL err_missing: got %b want 1", err); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL err_missing_rsp: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (idle !== 1'b0 || req_ready !== '0) $display("FAIL err_stuck_busy: got idle=%b rdy=%b want 0/0000", idle, req_ready); else n_pass++;
    drop = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic stray;
    do_reset('0);
    stray = 1'b0;
    req_x[2*X_W +: X_W] = 8'd4;
    req_valid = 4'b0100;
    #1;
    tick();
    tick();
    tick();
    rst_b = 1'b0;
    #1;
    n_checks++; if (q_x !== '0 || q_x_dv !== 1'b0) $display("FAIL rmid_q: got x=%0d dv=%b want 0/0", q_x, q_x_dv); else n_pass++;
    n_checks++; if (idle !== 1'b1 || err !== 1'b0) $display("FAIL rmid_idle_err: got idle=%b err=%b want 1/0", idle, err); else n_pass++;
    n_checks++; if (req_ready !== '0 || rsp_valid !== '0) $display("FAIL rmid_hs: got rdy=%b v=%b want 0/0", req_ready, rsp_valid); else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #2;
    req_valid = '0;
    rst_b = 1'b1;
    model_init();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid !== '0 || q_y_dv !== 1'b0) stray = 1'b1;
      tick();
    end
    n_checks++; if (stray !== 1'b0) $display("FAIL rmid_no_rsp: got stray=%b want 0", stray); else n_pass++;
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] exp_r;
    do_reset('0);
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      rsp_ready = N'($urandom) | N'($urandom);
      for (int i = 0; i < int'(N); i++) req_x[i*X_W +: X_W] = X_W'($urandom);
      #1;
      g = model_pick();
      exp_r = (g >= 0) ? (N'(1) << g) : '0;
      n_checks++; if (req_ready !== exp_r) $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, exp_r); else n_pass++;
      n_checks++; if (q_x_dv !== m_qdv || q_x !== m_qx) $display("FAIL rnd_q c=%0d: got dv=%b x=%h want %b/%h", c, q_x_dv, q_x, m_qdv, m_qx); else n_pass++;
      n_checks++; if (rsp_valid !== m_rspv) $display("FAIL rnd_rsp_valid c=%0d: got %b want %b", c, rsp_valid, m_rspv); else n_pass++;
      for (int i = 0; i < int'(N); i++) begin
        if (m_rspv[i]) begin
          n_checks++; if (rsp_y[i*Y_W +: Y_W] !== m_rspy[i]) $display("FAIL rnd_rsp_y c=%0d ch%0d: got %h want %h", c, i, rsp_y[i*Y_W +: Y_W], m_rspy[i]); else n_pass++;
        end
      end
      n_checks++; if (idle !== (m_busy == '0) || err !== 1'b0) $display("FAIL rnd_idle_err c=%0d: got idle=%b err=%b want %b/0", c, idle, err, (m_busy == '0)); else n_pass++;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_init();
    test_reset();
    test_single();
    test_all_channels();
    test_backpressure();
    test_en_drop();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
